// File: rtl/mips_muldiv_if.sv
// ============================================================================
// Module      : mips_muldiv_if
// Description : Request/result bundle between the CPU pipeline and the
//               HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             clock_enable;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output clock_enable, start, op, op_a, op_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  clock_enable, start, op, op_a, op_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
// ============================================================================
// Module      : mips_muldiv_unit
// Description : MIPS HI/LO unit: radix-2 multiply, restoring divide, MTHI/MTLO.
//               Define MIPS_MULDIV_FAST_MUL_EN for a single-cycle multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mips_muldiv_if.slave      bus
);
    localparam int         CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [2:0] C_OP_MULT  = 3'd0;
    localparam logic [2:0] C_OP_MULTU = 3'd1;
    localparam logic [2:0] C_OP_DIV   = 3'd2;
    localparam logic [2:0] C_OP_DIVU  = 3'd3;
    localparam logic [2:0] C_OP_MTHI  = 3'd4;
    localparam logic [2:0] C_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0] r_acc_hi, w_acc_hi_nxt;
    logic [WIDTH-1:0] r_acc_lo, w_acc_lo_nxt;
    logic [WIDTH-1:0] r_opnd,   w_opnd_nxt;
    logic [WIDTH-1:0] r_hi,     w_hi_nxt;
    logic [WIDTH-1:0] r_lo,     w_lo_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic             r_neg_lo, w_neg_lo_nxt;
    logic             r_neg_hi, w_neg_hi_nxt;
    logic             r_dbz,    w_dbz_nxt;

    logic             w_accept;
    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_accept = bus.clock_enable && bus.start && (r_state != S_RUN)
                      && (bus.op <= C_OP_MTLO);
    assign w_signed = (bus.op == C_OP_MULT) || (bus.op == C_OP_DIV);
    assign w_sa     = w_signed && bus.op_a[WIDTH-1];
    assign w_sb     = w_signed && bus.op_b[WIDTH-1];
    assign w_mag_a  = w_sa ? -bus.op_a : bus.op_a;
    assign w_mag_b  = w_sb ? -bus.op_b : bus.op_b;

`ifdef MIPS_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_ext_a     = {{WIDTH{w_sa}}, bus.op_a};
    assign w_ext_b     = {{WIDTH{w_sb}}, bus.op_b};
    assign w_fast_prod = w_ext_a * w_ext_b;
`endif

    // Multiply: acc_hi accumulates, acc_lo holds the multiplier and shifts out.
    // Divide: acc_hi is the partial remainder, acc_lo dividend -> quotient.
    assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_opnd};

    always_comb begin
        w_it_hi = w_sum[WIDTH:1];
        w_it_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_trial[WIDTH]) begin
                w_it_hi = w_trial[WIDTH-1:0];
                w_it_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_it_hi = w_shift[WIDTH-1:0];
                w_it_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_prod_fix = r_neg_lo ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};
    assign w_fix_hi   = r_is_div ? (r_neg_hi ? -w_it_hi : w_it_hi)
                                 : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo   = r_is_div ? (r_neg_lo ? -w_it_lo : w_it_lo)
                                 : w_prod_fix[WIDTH-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_hi_nxt = r_acc_hi;
        w_acc_lo_nxt = r_acc_lo;
        w_opnd_nxt   = r_opnd;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_is_div_nxt = r_is_div;
        w_neg_lo_nxt = r_neg_lo;
        w_neg_hi_nxt = r_neg_hi;
        w_dbz_nxt    = r_dbz;

        if (r_state == S_RUN) begin
            w_acc_hi_nxt = w_it_hi;
            w_acc_lo_nxt = w_it_lo;
            w_cnt_nxt    = r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST) begin
                w_hi_nxt    = w_fix_hi;
                w_lo_nxt    = w_fix_lo;
                w_cnt_nxt   = '0;
                w_state_nxt = S_DONE;
            end
        end else if (w_accept) begin
            w_dbz_nxt    = 1'b0;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_DONE;
            w_neg_lo_nxt = w_sa ^ w_sb;
            w_neg_hi_nxt = w_sa;
            case (bus.op)
                C_OP_MTHI: w_hi_nxt = bus.op_a;
                C_OP_MTLO: w_lo_nxt = bus.op_a;
                C_OP_MULT, C_OP_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
                    w_hi_nxt = w_fast_prod[2*WIDTH-1:WIDTH];
                    w_lo_nxt = w_fast_prod[WIDTH-1:0];
`else
                    w_acc_hi_nxt = '0;
                    w_acc_lo_nxt = w_mag_b;
                    w_opnd_nxt   = w_mag_a;
                    w_is_div_nxt = 1'b0;
                    w_state_nxt  = S_RUN;
`endif
                end
                default: begin
                    if (bus.op_b == '0) begin
                        w_hi_nxt  = bus.op_a;
                        w_lo_nxt  = '1;
                        w_dbz_nxt = 1'b1;
                    end else begin
                        w_acc_hi_nxt = '0;
                        w_acc_lo_nxt = w_mag_a;
                        w_opnd_nxt   = w_mag_b;
                        w_is_div_nxt = 1'b1;
                        w_state_nxt  = S_RUN;
                    end
                end
            endcase
        end else if (r_state == S_DONE) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (bus.clock_enable) begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc_hi <= w_acc_hi_nxt;
            r_acc_lo <= w_acc_lo_nxt;
            r_opnd   <= w_opnd_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg_lo <= w_neg_lo_nxt;
            r_neg_hi <= w_neg_hi_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule

`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
// ============================================================================
// Module      : tb_mips_muldiv_unit
// Description : Self-checking bench for mips_muldiv_unit against an
//               arithmetic reference model (64-bit integer math).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mips_muldiv_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: results from plain integer arithmetic on the operands.
    task automatic predict(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el,
                           output logic edbz, output int ebusy);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        eh = m_hi; el = m_lo; edbz = 1'b0; ebusy = 0;
        case (op)
            3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; ebusy = W; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; ebusy = W; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF; edbz = 1'b1;
                end else if (op == 3'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    el = sq[31:0]; eh = sr[31:0]; ebusy = W;
                end else begin
                    uq = a / b; ur = a % b;
                    el = uq; eh = ur; ebusy = W;
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
`ifdef MIPS_MULDIV_FAST_MUL_EN
        if (op <= 3'd1) ebusy = 0;
`endif
    endtask

    // Entered at the negedge after the acceptance edge; returns at the done negedge
    // (or after the tail check when tail=1).
    task automatic wait_done(input string tag, input int ebusy, input logic [31:0] eh,
                             input logic [31:0] el, input logic edbz,
                             input bit rnd_ce, input bit scramble, input bit tail);
        int bcnt = 0;
        int cyc = 0;
        bit seen = 0;
        while (cyc < 400 && !seen) begin
            if (bus.done) seen = 1;
            else begin
                if (scramble) begin bus.op_a = $urandom; bus.op_b = $urandom; end
                if (rnd_ce) bus.clock_enable = ($urandom_range(0, 2) != 0);
                if (bus.busy && bus.clock_enable) bcnt++;
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(ebusy));
        chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        m_hi = eh; m_lo = el;
        if (tail) begin
            if (rnd_ce) begin
                bus.clock_enable = 1'b0;
                @(negedge clk);
                chk({tag, "_done_hold"}, 64'(bus.done), 64'd1);
                bus.clock_enable = 1'b1;
            end
            @(negedge clk);
            chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit rnd_ce);
        logic [31:0] eh, el;
        logic edbz;
        int ebusy;
        predict(op, a, b, eh, el, edbz, ebusy);
        @(negedge clk);
        bus.clock_enable = 1'b1; bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tag, ebusy, eh, el, edbz, rnd_ce, 1'b1, 1'b1);
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic edbz;
        int ebusy;
        bit any_done;
        logic [2:0] rop;

        reset = 1'b0;
        bus.clock_enable = 1'b0; bus.start = 1'b0; bus.op = 3'd0;
        bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        reset = 1'b1;
        bus.clock_enable = 1'b1;

        run_op("mult_neg2x3",  3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op("multu_big",    3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op("div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_min_m1",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_zero",    3'd3, 32'h1234_5678, 32'd0, 1'b0);
        run_op("mtlo",         3'd5, 32'hCAFE_BABE, 32'd0, 1'b0);
        run_op("mthi",         3'd4, 32'h0BAD_F00D, 32'd0, 1'b0);
        run_op("div_cleardbz", 3'd2, 32'd100, 32'hFFFF_FFF9, 1'b0);
`ifdef MIPS_MULDIV_FAST_MUL_EN
        run_op("fast_multu",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`endif

        // Reserved op: nothing changes.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd6; bus.op_a = 32'h1111_2222;
        @(negedge clk);
        bus.op = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rsvd_busy", 64'(bus.busy), 64'd0);
        chk("rsvd_done", 64'(bus.done), 64'd0);
        chk("rsvd_hi", 64'(bus.hi), 64'(m_hi));
        chk("rsvd_lo", 64'(bus.lo), 64'(m_lo));

        // Start held with another op during RUN is ignored, then taken in DONE.
        predict(3'd1, 32'hDEAD_BEEF, 32'h0000_1234, eh, el, edbz, ebusy);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h0000_1234;
        @(negedge clk);
        bus.op = 3'd3; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        wait_done("chain1", ebusy, eh, el, edbz, 1'b0, 1'b0, 1'b0);
        predict(3'd3, 32'd1000, 32'd7, eh, el, edbz, ebusy);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("chain2", ebusy, eh, el, edbz, 1'b0, 1'b1, 1'b1);

        // Randomized operations, some with a stuttering clock enable.
        for (int i = 0; i < 20; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_op($sformatf("rnd%0d", i), rop, ra, rb, (i % 3) == 0);
        end

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.op_a = 32'h1234_5678; bus.op_b = 32'h0000_0FFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        any_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) any_done = 1;
        end
        chk("abort_no_done", 64'(any_done), 64'd0);
        m_hi = '0; m_lo = '0;

        // Reset and start on the same edge: reset wins.
        reset = 1'b0;
        bus.start = 1'b1; bus.op = 3'd4; bus.op_a = 32'h0000_0055;
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b0;
        chk("rst_start_hi", 64'(bus.hi), 64'd0);
        chk("rst_start_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("rst_start_done2", 64'(bus.done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
